// File: rtl/rapid_dmem_responder_if.sv
// Request/response bus between a data-cache requester and the data memory responder.
//  req_valid/req_ready : request handshake (transfer when both high at a rising edge)
//  req_rw              : 0 = read, 1 = write
//  req_op              : 0 = NOP, 1 = byte, 2 = half word, 3 = word
//  req_addr            : byte address
//  req_wdata           : LSB-justified write data
//  resp_valid          : one-cycle response strobe
//  resp_rdata          : LSB-justified, zero-extended read data
//  resp_error          : request rejected (misaligned or out of range)
interface rapid_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_rw, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_rw, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/rapid_dmem_responder.sv
// Single-outstanding data memory responder: accepts one request, waits LATENCY
// cycles, performs a byte/half/word access on a word-organised array and
// returns a one-cycle response.
//  clk     : rising-edge clock
//  reset_n : synchronous active-low reset
//  bus     : slave side of rapid_dmem_responder_if
// DEPTH_WORDS must be a power of 2 (>= 2); LATENCY must be 0..15.
module rapid_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  rapid_dmem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_BYTE = 2'd1;
  localparam logic [1:0] OP_HALF = 2'd2;
  localparam logic [1:0] OP_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ready;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            resp_error;

  logic            lat_rw;
  logic [1:0]      lat_op;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx_c;
  logic [31:0]     rd_word_c;
  logic [31:0]     rd_shift_c;
  logic            range_err_c;
  logic            align_err_c;
  logic            err_c;
  logic            access_c;
  logic            we_c;
  logic [3:0]      be_c;
  logic [31:0]     wd_c;
  logic [31:0]     rdata_c;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_error = resp_error;

  // Decode of the latched request; evaluated in the cycle the access happens.
  always_comb begin
    idx_c       = lat_addr[AW+1:2];
    rd_word_c   = mem[idx_c];
    // Byte lane select: for legal half/word accesses the low bits keep this correct.
    rd_shift_c  = rd_word_c >> {lat_addr[1:0], 3'b000};
    range_err_c = 32'(lat_addr[31:2]) >= 32'(DEPTH_WORDS);
    align_err_c = ((lat_op == OP_HALF) && lat_addr[0]) ||
                  ((lat_op == OP_WORD) && (lat_addr[1:0] != 2'b00));
    // NOP never touches the array, so it is never rejected.
    err_c       = (lat_op != OP_NOP) && (range_err_c || align_err_c);
    access_c    = (state == ST_WAIT) && (cnt == CW'(LATENCY));

    rdata_c = 32'd0;
    if (!err_c && !lat_rw) begin
      case (lat_op)
        OP_BYTE: rdata_c = {24'd0, rd_shift_c[7:0]};
        OP_HALF: rdata_c = {16'd0, rd_shift_c[15:0]};
        OP_WORD: rdata_c = rd_word_c;
        default: rdata_c = 32'd0;
      endcase
    end

    be_c = 4'b0000;
    wd_c = lat_wdata;
    case (lat_op)
      OP_BYTE: begin
        be_c = 4'(4'b0001 << lat_addr[1:0]);
        wd_c = {4{lat_wdata[7:0]}};
      end
      OP_HALF: begin
        be_c = lat_addr[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{lat_wdata[15:0]}};
      end
      OP_WORD: be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase

    // Reset on the commit edge drops the write along with the response.
    we_c = access_c && lat_rw && !err_c && (lat_op != OP_NOP) && reset_n;
  end

  // Request sequencing and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ready      <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      lat_rw     <= 1'b0;
      lat_op     <= OP_NOP;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && ready) begin
            lat_rw    <= bus.req_rw;
            lat_op    <= bus.req_op;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            ready     <= 1'b0;
            cnt       <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (access_c) begin
            resp_valid <= 1'b1;
            resp_rdata <= rdata_c;
            resp_error <= err_c;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          ready      <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage array with per-lane write enables; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem[idx_c][8*b +: 8] <= wd_c[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rapid_dmem_responder.sv
// Testbench for rapid_dmem_responder: byte-addressed reference model with a
// response scoreboard checked by an independent monitor process.
module tb_rapid_dmem_responder;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LAT     = 2;
  localparam int unsigned NBYTES  = DEPTH * 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   nchk;
  int   npass;
  exp_t sb[$];
  logic [7:0] mbytes [NBYTES];

  rapid_dmem_responder_if dif();

  rapid_dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour at byte granularity.
  function automatic void model(input logic rw, input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int nb;
    nb  = (op == 2'd1) ? 1 : (op == 2'd2) ? 2 : (op == 2'd3) ? 4 : 0;
    rd  = 32'd0;
    err = 1'b0;
    if (nb == 0) return;
    if ((addr % nb) != 0 || addr >= 32'(NBYTES)) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < nb; k++) begin
      if (rw) mbytes[int'(addr) + k] = wd[8*k +: 8];
      else    rd[8*k +: 8] = mbytes[int'(addr) + k];
    end
  endfunction

  // Issue one request; hold keeps req_valid asserted for extra cycles while busy.
  task automatic do_req(input logic rw, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    dif.req_rw    = rw;
    dif.req_op    = op;
    dif.req_addr  = addr;
    dif.req_wdata = wd;
    dif.req_valid = 1'b1;
    while (!dif.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dif.req_ready) begin
      check("ready_timeout", 64'(dif.req_ready), 64'd1);
      dif.req_valid = 1'b0;
      return;
    end
    model(rw, op, addr, wd, e.rdata, e.err);
    e.cyc = cyc + 2 + int'(LAT);
    sb.push_back(e);
    repeat (hold + 1) @(negedge clk);
    dif.req_valid = 1'b0;
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dif.resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
          check("resp_error", 64'(dif.resp_error), 64'(e.err));
          check("resp_rdata", 64'(dif.resp_rdata), 64'(e.rdata));
        end
      end
    end
  end

  initial begin
    logic        rw;
    logic [1:0]  op;
    logic [31:0] addr;
    int          n;
    nchk          = 0;
    npass         = 0;
    reset_n       = 1'b0;
    dif.req_valid = 1'b0;
    dif.req_rw    = 1'b0;
    dif.req_op    = 2'd0;
    dif.req_addr  = 32'd0;
    dif.req_wdata = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(dif.req_ready), 64'd1);
    check("rst_valid", 64'(dif.resp_valid), 64'd0);
    check("rst_rdata", 64'(dif.resp_rdata), 64'd0);
    check("rst_error", 64'(dif.resp_error), 64'd0);
    reset_n = 1'b1;

    // Give every word a known value.
    for (int w = 0; w < int'(DEPTH); w++) do_req(1'b1, 2'd3, 32'(w * 4), $urandom, 0);

    // Word write/read round trip.
    do_req(1'b1, 2'd3, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'd3, 32'h10, 32'h0, 0);
    // Sub-word merge and reads.
    do_req(1'b1, 2'd1, 32'h13, 32'h55, 0);
    do_req(1'b0, 2'd2, 32'h12, 32'h0, 0);
    do_req(1'b0, 2'd1, 32'h11, 32'h0, 0);
    // Misaligned accesses leave the array untouched.
    do_req(1'b0, 2'd2, 32'h11, 32'h0, 0);
    do_req(1'b1, 2'd3, 32'h16, 32'hCAFEF00D, 0);
    do_req(1'b0, 2'd3, 32'h14, 32'h0, 0);
    // Out of range and NOP.
    do_req(1'b0, 2'd3, 32'(NBYTES), 32'h0, 0);
    do_req(1'b0, 2'd3, 32'(NBYTES - 4), 32'h0, 0);
    do_req(1'b0, 2'd0, 32'h0, 32'h0, 0);

    // Reset one cycle after accepting a write: no response, no commit.
    @(negedge clk);
    dif.req_rw    = 1'b1;
    dif.req_op    = 2'd3;
    dif.req_addr  = 32'h20;
    dif.req_wdata = 32'h12345678;
    dif.req_valid = 1'b1;
    n = 0;
    while (!dif.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_accept", 64'(dif.req_ready), 64'd1);
    @(negedge clk);
    reset_n       = 1'b0;
    dif.req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_ready", 64'(dif.req_ready), 64'd1);
    check("mid_rst_valid", 64'(dif.resp_valid), 64'd0);
    repeat (6) @(negedge clk);
    do_req(1'b0, 2'd3, 32'h20, 32'h0, 0);

    // Randomized traffic, including held req_valid while busy.
    for (int i = 0; i < 300; i++) begin
      rw = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(NBYTES, NBYTES + 40));
        default: addr = 32'($urandom_range(0, NBYTES - 1));
      endcase
      if (op == 2'd0) addr = addr % 32'(NBYTES);
      do_req(rw, op, addr, $urandom, int'($urandom_range(0, 3)));
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
